// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: clips a command to the framebuffer and streams one pixel write per clock.
// Define FB_RECT_OUTLINE_EN to add the i_outline port (hollow rectangles, same iteration timing).
module fb_rect_writer #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [X_W-1:0]     i_x0,
    input  logic [Y_W-1:0]     i_y0,
    input  logic [X_W-1:0]     i_w,
    input  logic [Y_W-1:0]     i_h,
    input  logic [COLOR_W-1:0] i_color,
    input  logic               i_abort,
`ifdef FB_RECT_OUTLINE_EN
    input  logic               i_outline,
`endif
    output logic [ADDR_W-1:0]  o_addr,
    output logic [COLOR_W-1:0] o_data,
    output logic               o_we,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLIP = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [X_W:0]      H_LIM  = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]      V_LIM  = (Y_W+1)'(V_RES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    logic [1:0]         state_reg;
    logic [X_W-1:0]     x0_reg, w_reg, xe_reg, col_reg;
    logic [Y_W-1:0]     y0_reg, h_reg, ye_reg, row_reg;
    logic [COLOR_W-1:0] color_reg;
    logic [ADDR_W-1:0]  base_reg;

    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;
    logic [X_W-1:0]     xe_next;
    logic [Y_W-1:0]     ye_next;
    logic               clip_empty;
    logic [ADDR_W-1:0]  base_next;
    logic [ADDR_W-1:0]  base_terms [ADDR_W];
    logic               last_col, last_row, pixel_on;

    // Sums are one bit wider than the fields so large x0+w / y0+h cannot wrap.
    assign sum_x = {1'b0, x0_reg} + {1'b0, w_reg};
    assign sum_y = {1'b0, y0_reg} + {1'b0, h_reg};
    assign xe_next = (sum_x > H_LIM) ? X_W'(H_RES - 1) : X_W'(sum_x - 1'b1);
    assign ye_next = (sum_y > V_LIM) ? Y_W'(V_RES - 1) : Y_W'(sum_y - 1'b1);
    assign clip_empty = (w_reg == '0) || (h_reg == '0) ||
                        ({1'b0, x0_reg} >= H_LIM) || ({1'b0, y0_reg} >= V_LIM);

    // Row base y0*H_RES as a sum of shifted copies of y0, one per set bit of H_RES.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_row_mul
            if (H_STEP[gi]) begin : g_term
                assign base_terms[gi] = ADDR_W'(y0_reg) << gi;
            end else begin : g_zero
                assign base_terms[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        base_next = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            base_next = base_next + base_terms[i];
        end
    end

    assign last_col = (col_reg == xe_reg);
    assign last_row = (row_reg == ye_reg);

`ifdef FB_RECT_OUTLINE_EN
    logic outline_reg;
    assign pixel_on = ~outline_reg | (row_reg == y0_reg) | last_row |
                      (col_reg == x0_reg) | last_col;
`else
    assign pixel_on = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            x0_reg    <= '0;
            y0_reg    <= '0;
            w_reg     <= '0;
            h_reg     <= '0;
            xe_reg    <= '0;
            ye_reg    <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            color_reg <= '0;
            base_reg  <= '0;
`ifdef FB_RECT_OUTLINE_EN
            outline_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        x0_reg    <= i_x0;
                        y0_reg    <= i_y0;
                        w_reg     <= i_w;
                        h_reg     <= i_h;
                        color_reg <= i_color;
`ifdef FB_RECT_OUTLINE_EN
                        outline_reg <= i_outline;
`endif
                        state_reg <= ST_CLIP;
                    end
                end
                ST_CLIP: begin
                    xe_reg    <= xe_next;
                    ye_reg    <= ye_next;
                    base_reg  <= base_next;
                    col_reg   <= x0_reg;
                    row_reg   <= y0_reg;
                    state_reg <= clip_empty ? ST_DONE : ST_FILL;
                end
                ST_FILL: begin
                    if (i_abort) begin
                        state_reg <= ST_DONE;
                    end else if (last_col) begin
                        col_reg  <= x0_reg;
                        row_reg  <= row_reg + 1'b1;
                        base_reg <= base_reg + H_STEP;
                        if (last_row) begin
                            state_reg <= ST_DONE;
                        end
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_cmd_ready = ~o_busy;
    assign o_done      = (state_reg == ST_DONE);
    assign o_we        = (state_reg == ST_FILL) && pixel_on;
    assign o_addr      = (state_reg == ST_FILL) ? (base_reg + ADDR_W'(col_reg)) : '0;
    assign o_data      = (state_reg == ST_FILL) ? color_reg : '0;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: randomized rectangles against a row/column reference model.
// Outline checks are compiled in when FB_RECT_OUTLINE_EN is defined.
module tb_fb_rect_writer;
    localparam int X_W = 9, Y_W = 8, ADDR_W = 17, COLOR_W = 3;
    localparam int MAXT = 4096;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_cmd_valid = 1'b0;
    logic               i_abort = 1'b0;
    logic               i_outline = 1'b0;
    logic [X_W-1:0]     i_x0 = '0, i_w = '0;
    logic [Y_W-1:0]     i_y0 = '0, i_h = '0;
    logic [COLOR_W-1:0] i_color = '0;
    logic               o_cmd_ready, o_we, o_busy, o_done;
    logic [ADDR_W-1:0]  o_addr;
    logic [COLOR_W-1:0] o_data;

    fb_rect_writer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_x0(i_x0), .i_y0(i_y0), .i_w(i_w), .i_h(i_h), .i_color(i_color), .i_abort(i_abort),
`ifdef FB_RECT_OUTLINE_EN
        .i_outline(i_outline),
`endif
        .o_addr(o_addr), .o_data(o_data), .o_we(o_we), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

`ifdef FB_RECT_OUTLINE_EN
    localparam bit OUTLINE_EN = 1'b1;
`else
    localparam bit OUTLINE_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Trace index 0 is the cycle right after the accepting edge.
    logic               tr_we [MAXT], tr_done [MAXT], tr_ready [MAXT], tr_busy [MAXT];
    logic [ADDR_W-1:0]  tr_addr [MAXT];
    logic [COLOR_W-1:0] tr_data [MAXT];
    bit                 exp_we [MAXT];
    int                 exp_addr [MAXT];

    task automatic record(input int j);
        tr_we[j] = o_we; tr_done[j] = o_done; tr_ready[j] = o_cmd_ready; tr_busy[j] = o_busy;
        tr_addr[j] = o_addr; tr_data[j] = o_data;
    endtask

    // Reference: visit every clipped pixel row-major, one iteration per pixel.
    function automatic int model_rect(input int x0, input int y0, input int w, input int h,
                                      input bit outline);
        int xe, ye, n;
        if (w == 0 || h == 0 || x0 >= 320 || y0 >= 240) return 0;
        xe = ((x0 + w) < 320 ? (x0 + w) : 320) - 1;
        ye = ((y0 + h) < 240 ? (y0 + h) : 240) - 1;
        n = 0;
        for (int r = y0; r <= ye; r++) begin
            for (int c = x0; c <= xe; c++) begin
                exp_addr[n] = r * 320 + c;
                exp_we[n]   = !outline || r == y0 || r == ye || c == x0 || c == xe;
                n++;
            end
        end
        return n;
    endfunction

    task automatic drive_cmd(input int x0, input int y0, input int w, input int h, input int color,
                             input bit outline, input bit clip_abort, input int abort_at,
                             input int ncyc, output int writes);
        for (int t = 0; t < 64 && o_cmd_ready !== 1'b1; t++) @(negedge i_clk);
        n_tests++;
        if (o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: o_cmd_ready=%b want 1", o_cmd_ready);
        end
        i_x0 = X_W'(x0); i_y0 = Y_W'(y0); i_w = X_W'(w); i_h = Y_W'(h);
        i_color = COLOR_W'(color); i_outline = outline; i_abort = clip_abort;
        i_cmd_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_x0 = X_W'($urandom); i_y0 = Y_W'($urandom); i_w = X_W'($urandom);
        i_h = Y_W'($urandom); i_color = COLOR_W'($urandom); i_outline = 1'($urandom);
        writes = 0;
        for (int j = 0; j < ncyc; j++) begin
            if (j > 0) @(negedge i_clk);
            record(j);
            if (o_we === 1'b1) writes++;
            if (j == 0) i_abort = clip_abort;
            else i_abort = (abort_at > 0 && o_we === 1'b1 && writes == abort_at);
        end
        i_abort = 1'b0;
        $display("[TB] cmd x0=%0d y0=%0d w=%0d h=%0d color=%0d outline=%0b abort_at=%0d writes=%0d",
                 x0, y0, w, h, color, outline, abort_at, writes);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_tests += 6;
        if (o_we !== 1'b0)        begin n_fail++; $display("FAIL reset_we: got %b want 0", o_we); end
        if (o_addr !== '0)        begin n_fail++; $display("FAIL reset_addr: got %0d want 0", o_addr); end
        if (o_data !== '0)        begin n_fail++; $display("FAIL reset_data: got %0d want 0", o_data); end
        if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        if (o_done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
        if (o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_cmd_ready); end
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        n_tests++;
        if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: ready=%b busy=%b want 1/0", o_cmd_ready, o_busy);
        end
    endtask

    task automatic test_fill();
        int tx0[8] = '{10, 318, 10, 320, 5, 300, 30, 100};
        int ty0[8] = '{5, 239, 10, 5, 240, 0, 200, 100};
        int tw[8]  = '{3, 5, 0, 4, 4, 511, 4, 4};
        int th[8]  = '{2, 5, 5, 4, 4, 2, 255, 0};
        int x0, y0, w, h, color, iters, writes;
        bit outline, clip_abort;
        for (int c = 0; c < 36; c++) begin
            if (c < 8) begin
                x0 = tx0[c]; y0 = ty0[c]; w = tw[c]; h = th[c]; color = 5 - (c % 5); outline = 1'b0;
            end else begin
                x0 = $urandom_range(0, 335); y0 = $urandom_range(0, 250);
                if ($urandom_range(0, 3) == 0) begin
                    w = $urandom_range(0, 511); h = $urandom_range(0, 3);
                end else begin
                    w = $urandom_range(0, 30); h = $urandom_range(0, 12);
                end
                color = $urandom_range(0, 7);
                outline = OUTLINE_EN ? 1'($urandom) : 1'b0;
            end
            clip_abort = 1'($urandom);
            iters = model_rect(x0, y0, w, h, outline);
            drive_cmd(x0, y0, w, h, color, outline, clip_abort, 0, iters + 3, writes);
            n_tests++;
            if (tr_busy[0] !== 1'b1 || tr_we[0] !== 1'b0) begin
                n_fail++; $display("FAIL fill_clip_cycle cmd %0d: busy=%b we=%b want 1/0", c, tr_busy[0], tr_we[0]);
            end
            for (int k = 0; k < iters; k++) begin
                n_tests++;
                if (tr_we[k+1] !== exp_we[k]) begin
                    n_fail++; $display("FAIL fill_we cmd %0d iter %0d: got %b want %b", c, k, tr_we[k+1], exp_we[k]);
                end else if (exp_we[k] && (tr_addr[k+1] !== ADDR_W'(exp_addr[k]) || tr_data[k+1] !== COLOR_W'(color))) begin
                    n_fail++; $display("FAIL fill_pixel cmd %0d iter %0d: addr=%0d data=%0d want %0d/%0d",
                                       c, k, tr_addr[k+1], tr_data[k+1], exp_addr[k], color);
                end
            end
            n_tests += 2;
            if (tr_done[iters+1] !== 1'b1 || tr_we[iters+1] !== 1'b0) begin
                n_fail++; $display("FAIL fill_done cmd %0d: done=%b we=%b want 1/0", c, tr_done[iters+1], tr_we[iters+1]);
            end
            if (tr_ready[iters+2] !== 1'b1 || tr_done[iters+2] !== 1'b0) begin
                n_fail++; $display("FAIL fill_ready cmd %0d: ready=%b done=%b want 1/0", c, tr_ready[iters+2], tr_done[iters+2]);
            end
        end
    endtask

    task automatic test_abort();
        int writes, n;
        drive_cmd(0, 0, 320, 240, 6, 1'b0, 1'b0, 100, 106, writes);
        n = 0;
        while (n < 105 && tr_we[n+1] === 1'b1) n++;
        n_tests++;
        if (n != 100 && n != 101) begin
            n_fail++; $display("FAIL abort_count: got %0d writes want 100 or 101", n);
        end
        for (int k = 0; k < n; k++) begin
            n_tests++;
            if (tr_addr[k+1] !== ADDR_W'(k)) begin
                n_fail++; $display("FAIL abort_addr write %0d: got %0d want %0d", k, tr_addr[k+1], k);
            end
        end
        n_tests += 2;
        if (tr_done[n+1] !== 1'b1) begin
            n_fail++; $display("FAIL abort_done: got %b want 1", tr_done[n+1]);
        end
        if (tr_ready[n+2] !== 1'b1) begin
            n_fail++; $display("FAIL abort_idle: ready=%b want 1", tr_ready[n+2]);
        end
    endtask

    task automatic test_reset_mid_fill();
        int writes, iters;
        drive_cmd(0, 0, 320, 240, 7, 1'b0, 1'b0, 0, 20, writes);
        n_tests++;
        if (o_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we: got %b want 1", o_we); end
        i_reset = 1'b1;
        #1;
        n_tests += 4;
        if (o_we !== 1'b0)        begin n_fail++; $display("FAIL rst_async_we: got %b want 0", o_we); end
        if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", o_busy); end
        if (o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %b want 1", o_cmd_ready); end
        if (o_addr !== '0)        begin n_fail++; $display("FAIL rst_async_addr: got %0d want 0", o_addr); end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        iters = model_rect(1, 1, 2, 2, 1'b0);
        drive_cmd(1, 1, 2, 2, 3, 1'b0, 1'b0, 0, iters + 3, writes);
        for (int k = 0; k < iters; k++) begin
            n_tests++;
            if (tr_we[k+1] !== 1'b1 || tr_addr[k+1] !== ADDR_W'(exp_addr[k]) || tr_data[k+1] !== 3'd3) begin
                n_fail++; $display("FAIL rst_refill iter %0d: we=%b addr=%0d data=%0d want 1/%0d/3",
                                   k, tr_we[k+1], tr_addr[k+1], tr_data[k+1], exp_addr[k]);
            end
        end
        n_tests++;
        if (tr_done[iters+1] !== 1'b1) begin n_fail++; $display("FAIL rst_refill_done: got %b want 1", tr_done[iters+1]); end
    endtask

    task automatic test_back_to_back();
        int ia, ib, b0;
        int a_addr[$], b_addr[$];
        ia = model_rect(5, 5, 4, 2, 1'b0);
        for (int k = 0; k < ia; k++) a_addr.push_back(exp_addr[k]);
        ib = model_rect(100, 50, 3, 3, 1'b0);
        for (int k = 0; k < ib; k++) b_addr.push_back(exp_addr[k]);
        @(negedge i_clk);
        i_x0 = 9'd5; i_y0 = 8'd5; i_w = 9'd4; i_h = 8'd2; i_color = 3'd3; i_outline = 1'b0;
        i_cmd_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        // Command B is held while A runs; it must only be taken after A's DONE.
        i_x0 = 9'd100; i_y0 = 8'd50; i_w = 9'd3; i_h = 8'd3; i_color = 3'd6;
        for (int j = 0; j < ia + ib + 6; j++) begin
            if (j > 0) @(negedge i_clk);
            record(j);
            if (j == ia + 3) i_cmd_valid = 1'b0;
        end
        i_cmd_valid = 1'b0;
        $display("[TB] cmd back_to_back A=(5,5,4,2) B=(100,50,3,3)");
        for (int k = 0; k < ia; k++) begin
            n_tests++;
            if (tr_we[k+1] !== 1'b1 || tr_addr[k+1] !== ADDR_W'(a_addr[k]) || tr_data[k+1] !== 3'd3) begin
                n_fail++; $display("FAIL b2b_a iter %0d: we=%b addr=%0d data=%0d want 1/%0d/3",
                                   k, tr_we[k+1], tr_addr[k+1], tr_data[k+1], a_addr[k]);
            end
        end
        n_tests += 3;
        if (tr_done[ia+1] !== 1'b1) begin n_fail++; $display("FAIL b2b_a_done: got %b want 1", tr_done[ia+1]); end
        if (tr_ready[ia+2] !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready: got %b want 1", tr_ready[ia+2]); end
        if (tr_busy[ia+3] !== 1'b1 || tr_we[ia+3] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_b_clip: busy=%b we=%b want 1/0", tr_busy[ia+3], tr_we[ia+3]);
        end
        b0 = ia + 4;
        for (int k = 0; k < ib; k++) begin
            n_tests++;
            if (tr_we[b0+k] !== 1'b1 || tr_addr[b0+k] !== ADDR_W'(b_addr[k]) || tr_data[b0+k] !== 3'd6) begin
                n_fail++; $display("FAIL b2b_b iter %0d: we=%b addr=%0d data=%0d want 1/%0d/6",
                                   k, tr_we[b0+k], tr_addr[b0+k], tr_data[b0+k], b_addr[k]);
            end
        end
        n_tests++;
        if (tr_done[b0+ib] !== 1'b1) begin n_fail++; $display("FAIL b2b_b_done: got %b want 1", tr_done[b0+ib]); end
    endtask

`ifdef FB_RECT_OUTLINE_EN
    task automatic test_outline();
        int want_addr[9] = '{0, 1, 2, 320, 321, 322, 640, 641, 642};
        bit want_we[9]   = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        int writes;
        drive_cmd(0, 0, 3, 3, 2, 1'b1, 1'b0, 0, 12, writes);
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (tr_we[k+1] !== want_we[k] || (want_we[k] && tr_addr[k+1] !== ADDR_W'(want_addr[k]))) begin
                n_fail++; $display("FAIL outline iter %0d: we=%b addr=%0d want %b/%0d",
                                   k, tr_we[k+1], tr_addr[k+1], want_we[k], want_addr[k]);
            end
        end
        n_tests++;
        if (tr_done[10] !== 1'b1) begin n_fail++; $display("FAIL outline_done: got %b want 1", tr_done[10]); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_abort();
        test_reset_mid_fill();
        test_back_to_back();
`ifdef FB_RECT_OUTLINE_EN
        test_outline();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
